spi_master_cfg: RTL and testbench

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

---
 rtl/spi_master_cfg.sv | 157 +++++++++++++++
 tb/tb_spi_master_cfg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: one frame per start. The mode (cpol/cpha), the bit order
// and the slave select are latched when the transfer is accepted.
module spi_master_cfg #(
  parameter  int DATA_W  = 8,
  parameter  int CLK_DIV = 4,
  parameter  int NUM_SS  = 1,
  localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t              r_state, w_next;
  logic [DIV_W-1:0]    r_div;
  logic [HALF_W-1:0]   r_half;
  logic                r_sclk, r_mosi, r_done, r_cpha, r_lsb;
  logic [SS_W-1:0]     r_ss;
  logic [DATA_W-1:0]   r_tx, r_rx, r_data_out;

  logic                w_tick, w_accept, w_edge, w_lead, w_last_edge;
  logic [HALF_W-1:0]   w_edge_idx;
  logic                w_tx_bit, w_first_bit;
  logic [DATA_W-1:0]   w_tx_shift, w_rx_shift, w_din_shift;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_accept = (r_state == S_IDLE) && start;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SETUP;
      S_SETUP: if (w_tick) w_next = S_XFER;
      S_XFER:  if (w_tick && (r_half == HALF_LAST)) w_next = S_HOLD;
      S_HOLD:  if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // SCLK edge k occurs on entry to XFER half-period k; even k are leading edges.
  always_comb begin
    w_edge      = 1'b0;
    w_edge_idx  = '0;
    if (r_state == S_SETUP && w_tick) begin
      w_edge = 1'b1;
    end else if (r_state == S_XFER && w_tick && (r_half != HALF_LAST)) begin
      w_edge     = 1'b1;
      w_edge_idx = r_half + 1'b1;
    end
    w_lead      = ~w_edge_idx[0];
    w_last_edge = (w_edge_idx == HALF_LAST);
  end

  assign w_tx_bit    = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
  assign w_tx_shift  = r_lsb ? {1'b0, r_tx[DATA_W-1:1]} : {r_tx[DATA_W-2:0], 1'b0};
  assign w_rx_shift  = r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
  assign w_first_bit = lsb_first ? data_in[0] : data_in[DATA_W-1];
  assign w_din_shift = lsb_first ? {1'b0, data_in[DATA_W-1:1]} : {data_in[DATA_W-2:0], 1'b0};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div      <= '0;
      r_half     <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_ss       <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) r_div <= '0;
      else                   r_div <= w_tick ? '0 : r_div + 1'b1;

      if (w_accept) begin
        r_cpha <= cpha;
        r_lsb  <= lsb_first;
        r_ss   <= ss_sel;
        r_sclk <= cpol;
        r_rx   <= '0;
        if (cpha) begin
          r_mosi <= 1'b0;
          r_tx   <= data_in;
        end else begin
          r_mosi <= w_first_bit;
          r_tx   <= w_din_shift;
        end
      end

      if (w_edge) begin
        r_sclk <= ~r_sclk;
        r_half <= w_edge_idx;
        if (w_lead) begin
          if (r_cpha) begin
            r_mosi <= w_tx_bit;
            r_tx   <= w_tx_shift;
          end else begin
            r_rx <= w_rx_shift;
          end
        end else if (r_cpha) begin
          r_rx <= w_rx_shift;
        end else if (!w_last_edge) begin
          r_mosi <= w_tx_bit;
          r_tx   <= w_tx_shift;
        end
      end

      if (r_state == S_HOLD && w_tick) begin
        r_data_out <= r_rx;
        r_done     <= 1'b1;
        r_mosi     <= 1'b0;
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign data_out = r_data_out;
  assign mosi     = r_mosi;
  assign sclk     = (r_state == S_IDLE) ? cpol : r_sclk;

  // An out-of-range latched index matches no line, so every select stays high.
  always_comb begin
    ss_n = '1;
    for (int i = 0; i < NUM_SS; i++) ss_n[i] = !(busy && (r_ss == SS_W'(i)));
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: directed frames on two configurations, expected frames
// queued at issue and compared by per-instance monitors on each done pulse.
module tb_spi_master_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instance A: 8-bit frames, CLK_DIV=4, four slave selects
  logic       a_start, a_cpol, a_cpha, a_lsb, a_miso, a_loop;
  logic [1:0] a_ss;
  logic [7:0] a_din;
  logic       a_sclk, a_mosi, a_busy, a_done;
  logic [3:0] a_ssn;
  logic [7:0] a_dout;
  logic [7:0] slave_tx;
  int         s_idx;

  assign a_miso = a_loop ? a_mosi : ((s_idx < 8) ? slave_tx[3'(7 - s_idx)] : 1'b0);

  spi_master_cfg #(.DATA_W(8), .CLK_DIV(4), .NUM_SS(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .cpol(a_cpol), .cpha(a_cpha),
    .lsb_first(a_lsb), .ss_sel(a_ss), .data_in(a_din), .miso(a_miso),
    .sclk(a_sclk), .mosi(a_mosi), .ss_n(a_ssn), .data_out(a_dout),
    .busy(a_busy), .done(a_done)
  );

  // Instance B: 16-bit frames, CLK_DIV=1, three slave selects, loopback
  logic        b_start, b_cpol, b_cpha, b_lsb;
  logic [1:0]  b_ss;
  logic [15:0] b_din;
  logic        b_sclk, b_mosi, b_busy, b_done;
  logic [2:0]  b_ssn;
  logic [15:0] b_dout;

  spi_master_cfg #(.DATA_W(16), .CLK_DIV(1), .NUM_SS(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .cpol(b_cpol), .cpha(b_cpha),
    .lsb_first(b_lsb), .ss_sel(b_ss), .data_in(b_din), .miso(b_mosi),
    .sclk(b_sclk), .mosi(b_mosi), .ss_n(b_ssn), .data_out(b_dout),
    .busy(b_busy), .done(b_done)
  );

  // Scoreboard state
  logic [7:0]  a_q[$];
  logic [15:0] b_q[$];
  logic        a_lead[$];
  logic        a_cur_cpol, a_prev_sclk, a_abort;
  logic [3:0]  a_exp_ssn;
  logic [2:0]  b_exp_ssn;
  int          a_bcnt = 0, b_bcnt = 0, a_dn = 0, b_dn = 0;

  always @(negedge clk) begin
    if (a_done) begin
      a_dn++;
      if (a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: got done with data_out 0x%0h, expected no done", a_dout);
      end else check("a_data_out", 32'(a_dout), 32'(a_q.pop_front()));
    end
    if (a_busy) begin
      a_bcnt++;
      check("a_ss_n", 32'(a_ssn), 32'(a_exp_ssn));
      if (a_sclk != a_prev_sclk) begin
        if (a_sclk != a_cur_cpol) a_lead.push_back(a_mosi);
        else                      s_idx++;
      end
    end else if (a_bcnt != 0) begin
      if (!a_abort) check("a_busy_len", 32'(a_bcnt), 32'd72);
      a_bcnt = 0;
    end
    a_prev_sclk = a_sclk;
  end

  always @(negedge clk) begin
    if (b_done) begin
      b_dn++;
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: got done with data_out 0x%0h, expected no done", b_dout);
      end else check("b_data_out", 32'(b_dout), 32'(b_q.pop_front()));
    end
    if (b_busy) begin
      b_bcnt++;
      check("b_ss_n", 32'(b_ssn), 32'(b_exp_ssn));
    end else if (b_bcnt != 0) begin
      check("b_busy_len", 32'(b_bcnt), 32'd34);
      b_bcnt = 0;
    end
  end

  task automatic a_go(input logic cpol_i, input logic cpha_i, input logic lsb_i,
                      input logic [1:0] ss_i, input logic [7:0] din_i, input logic loop_i,
                      input logic [7:0] exp_i, input bit push);
    @(negedge clk);
    a_cpol = cpol_i; a_cpha = cpha_i; a_lsb = lsb_i; a_ss = ss_i; a_din = din_i;
    a_loop = loop_i; a_cur_cpol = cpol_i; a_exp_ssn = ~(4'b0001 << ss_i);
    s_idx = 0;
    a_lead.delete();
    if (push) a_q.push_back(exp_i);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_wait_idle(input string name);
    int n = 0;
    while (a_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (a_busy) begin
      checks++; errors++;
      $display("FAIL %s: busy still high after %0d cycles, expected idle", name, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic b_wait_done(input string name);
    int n = 0;
    while (!b_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!b_done) begin
      checks++; errors++;
      $display("FAIL %s: no done after %0d cycles, expected done", name, n);
    end
  endtask

  function automatic logic [7:0] pack_lead(input bit lsb);
    logic [7:0] v = '0;
    for (int i = 0; i < a_lead.size(); i++) v = lsb ? {a_lead[i], v[7:1]} : {v[6:0], a_lead[i]};
    return v;
  endfunction

  initial begin
    int d0;
    rst = 1'b0; a_abort = 1'b0;
    a_start = 0; a_cpol = 0; a_cpha = 0; a_lsb = 0; a_ss = 0; a_din = 0; a_loop = 1;
    a_cur_cpol = 0; a_prev_sclk = 0; a_exp_ssn = 4'hF; slave_tx = 8'hCC; s_idx = 0;
    b_start = 0; b_cpol = 0; b_cpha = 0; b_lsb = 0; b_ss = 0; b_din = 0; b_exp_ssn = 3'h7;
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(a_sclk), 32'd0);
    check("rst_mosi", 32'(a_mosi), 32'd0);
    check("rst_ss_n", 32'(a_ssn), 32'hF);
    check("rst_data_out", 32'(a_dout), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    rst = 1'b1;

    // Mode 0, MSB first, slave returns 0xCC
    d0 = a_dn;
    a_go(0, 0, 0, 2'd0, 8'hAA, 0, 8'hCC, 1);
    a_wait_idle("a_mode0_timeout");
    check("a_mode0_edges", 32'(a_lead.size()), 32'd8);
    check("a_mode0_mosi", 32'(pack_lead(0)), 32'hAA);
    check("a_mode0_done_count", 32'(a_dn - d0), 32'd1);
    check("a_idle_mosi", 32'(a_mosi), 32'd0);

    // Mode 3, LSB first, loopback
    a_cpol = 1'b1;
    @(negedge clk);
    check("a_mode3_idle_sclk", 32'(a_sclk), 32'd1);
    a_go(1, 1, 1, 2'd1, 8'h01, 1, 8'h01, 1);
    a_wait_idle("a_mode3_timeout");
    check("a_mode3_mosi", 32'(pack_lead(1)), 32'h01);
    check("a_mode3_first_bit", 32'(a_lead[0]), 32'd1);
    check("a_mode3_end_sclk", 32'(a_sclk), 32'd1);

    // Second start 10 cycles in is ignored
    d0 = a_dn;
    a_go(0, 0, 0, 2'd0, 8'h3C, 1, 8'h3C, 1);
    repeat (9) @(negedge clk);
    a_din = 8'hFF; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_wait_idle("a_ignore_timeout");
    check("a_ignore_mosi", 32'(pack_lead(0)), 32'h3C);
    check("a_ignore_done_count", 32'(a_dn - d0), 32'd1);

    // ss_sel=2; configuration inputs change mid-transfer without effect
    a_go(0, 0, 0, 2'd2, 8'h5A, 1, 8'h5A, 1);
    repeat (20) @(negedge clk);
    a_ss = 2'd0; a_cpol = 1'b1; a_cpha = 1'b1; a_lsb = 1'b1; a_din = 8'h00;
    a_wait_idle("a_ss_timeout");
    check("a_ss_mosi", 32'(pack_lead(0)), 32'h5A);

    // Reset at cycle 30 aborts the frame
    d0 = a_dn;
    a_go(0, 0, 0, 2'd3, 8'h96, 1, 8'h00, 0);
    repeat (29) @(negedge clk);
    rst = 1'b0; a_abort = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    check("abort_sclk", 32'(a_sclk), 32'd0);
    check("abort_mosi", 32'(a_mosi), 32'd0);
    check("abort_ss_n", 32'(a_ssn), 32'hF);
    check("abort_data_out", 32'(a_dout), 32'd0);
    check("abort_busy", 32'(a_busy), 32'd0);
    repeat (80) @(negedge clk);
    check("abort_no_done", 32'(a_dn - d0), 32'd0);
    a_abort = 1'b0;
    a_go(0, 1, 0, 2'd3, 8'h77, 1, 8'h77, 1);
    a_wait_idle("a_after_abort_timeout");
    check("a_after_abort_done", 32'(a_dn - d0), 32'd1);

    // Instance B: mode 1 then mode 2 back-to-back, then an out-of-range select
    @(negedge clk);
    b_cpol = 0; b_cpha = 1; b_lsb = 0; b_ss = 2'd0; b_din = 16'hA5C3; b_exp_ssn = 3'b110;
    b_q.push_back(16'hA5C3);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_wait_done("b_frame1_timeout");
    b_cpol = 1; b_cpha = 0; b_q.push_back(16'hA5C3);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("b_back_to_back_busy", 32'(b_busy), 32'd1);
    b_wait_done("b_frame2_timeout");
    @(negedge clk);
    b_cpol = 0; b_cpha = 0; b_lsb = 1; b_ss = 2'd3; b_din = 16'h0F1E; b_exp_ssn = 3'b111;
    b_q.push_back(16'h0F1E);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_wait_done("b_frame3_timeout");
    repeat (3) @(negedge clk);
    check("b_done_count", 32'(b_dn), 32'd3);

    check("a_queue_empty", 32'(a_q.size()), 32'd0);
    check("b_queue_empty", 32'(b_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
